// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the CPU run/halt/step controller: FSM states, halt causes
// and the instruction word that stops the CPU.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_MAN  = 2'd0,
    CAUSE_BP   = 2'd1,
    CAUSE_EBRK = 2'd2,
    CAUSE_STEP = 2'd3
  } cause_t;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board/CPU-facing signal bundle of the run controller; the slave side is the
// controller itself, the master side is the board buttons plus the CPU.
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run_btn;
  logic             step_btn;
  logic             halt_btn;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc;
  logic [31:0]      instr;
  logic             cpu_reset;
  logic             cpu_ce;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] instret;

  modport slave (
    input  run_btn, step_btn, halt_btn, bp_en, bp_addr, pc, instr,
    output cpu_reset, cpu_ce, halted, halt_cause, instret
  );

  modport master (
    output run_btn, step_btn, halt_btn, bp_en, bp_addr, pc, instr,
    input  cpu_reset, cpu_ce, halted, halt_cause, instret
  );
endinterface

// File: rtl/cpu_run_ctrl_btn_pulse.sv
// Raw push-button to single-cycle pulse: two-flop synchroniser followed by a
// registered rising-edge detector (pulse appears three clocks after the edge).
module btn_pulse (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the single-cycle RV32I CPU: holds the CPU in
// reset after power-up, gates commits through cpu_ce and counts retired instructions.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 4,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] EBREAK     = EBREAK_INSN
) (
  input  logic         i_clock,
  input  logic         i_reset,
  cpu_run_ctrl_if.slave bus
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nx;
  cause_t           r_cause;
  cause_t           w_cause_nx;
  logic [RC_W-1:0]  r_rst_cnt;
  logic             r_skip_bp;
  logic [CNT_W-1:0] r_instret;
  logic             w_ce;
  logic             w_run_p;
  logic             w_step_p;
  logic             w_halt_p;
  logic             w_bp_hit;
  logic             w_eb_hit;
  logic             w_unused_lsb;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  btn_pulse u_run  (.i_clock(i_clock), .i_reset(i_reset), .i_btn(bus.run_btn),  .o_pulse(w_run_p));
  btn_pulse u_step (.i_clock(i_clock), .i_reset(i_reset), .i_btn(bus.step_btn), .o_pulse(w_step_p));
  btn_pulse u_halt (.i_clock(i_clock), .i_reset(i_reset), .i_btn(bus.halt_btn), .o_pulse(w_halt_p));

  // skip_bp lets a run resumed from a breakpoint commit the breakpoint instruction once
  assign w_bp_hit     = bus.bp_en && (bus.pc[31:2] == bus.bp_addr[31:2]) && !r_skip_bp;
  assign w_eb_hit     = (bus.instr == EBREAK);
  assign w_unused_lsb = ^{bus.pc[1:0], bus.bp_addr[1:0]};

  always_comb begin
    w_state_nx = r_state;
    w_cause_nx = r_cause;
    w_ce       = 1'b0;
    case (r_state)
      ST_RST: begin
        if (r_rst_cnt == RST_LAST) begin
          w_state_nx = ST_HALT;
          w_cause_nx = CAUSE_MAN;
        end
      end
      ST_HALT: begin
        if (w_run_p)       w_state_nx = ST_RUN;
        else if (w_step_p) w_state_nx = ST_STEP;
      end
      ST_RUN: begin
        if (w_halt_p) begin
          w_state_nx = ST_HALT;
          w_cause_nx = CAUSE_MAN;
        end else if (w_bp_hit) begin
          w_state_nx = ST_HALT;
          w_cause_nx = CAUSE_BP;
        end else if (w_eb_hit) begin
          w_state_nx = ST_HALT;
          w_cause_nx = CAUSE_EBRK;
        end else begin
          w_ce = 1'b1;
        end
      end
      ST_STEP: begin
        w_state_nx = ST_HALT;
        if (w_eb_hit) begin
          w_cause_nx = CAUSE_EBRK;
        end else begin
          w_cause_nx = CAUSE_STEP;
          w_ce       = 1'b1;
        end
      end
      default: w_state_nx = ST_RST;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_RST;
      r_cause   <= CAUSE_MAN;
      r_rst_cnt <= '0;
      r_skip_bp <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cause <= w_cause_nx;
      if (r_state == ST_RST && r_rst_cnt != RST_LAST) r_rst_cnt <= r_rst_cnt + 1'b1;
      if (r_state == ST_HALT && w_state_nx != ST_HALT) r_skip_bp <= 1'b1;
      else if (r_state == ST_RUN || r_state == ST_STEP) r_skip_bp <= 1'b0;
      if (w_ce) r_instret <= sat_inc(r_instret);
    end
  end

  // cpu_ce is combinational so a stop condition suppresses the commit in the same cycle
  assign bus.cpu_reset  = (r_state == ST_RST);
  assign bus.cpu_ce     = w_ce;
  assign bus.halted     = (r_state == ST_HALT);
  assign bus.halt_cause = r_cause;
  assign bus.instret    = r_instret;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus queues expected commits, halts,
// reset lengths and reset snapshots; monitors pop and compare as the DUT presents them.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam int CW = 8;

  typedef struct packed {
    logic [1:0]    cause;
    logic [CW-1:0] cnt;
  } halt_t;

  typedef struct packed {
    logic          cpu_reset;
    logic          cpu_ce;
    logic          halted;
    logic [CW-1:0] instret;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] eb_pc = 32'h20;
  logic        ce_s = 1'b0;
  logic        rst_s = 1'b1;
  logic        prev_h = 1'b0;
  logic        prev_cr = 1'b0;
  int          rlen = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [31:0] q_commit[$];
  halt_t       q_halt[$];
  int          q_rstlen[$];
  snap_t       q_snap[$];
  event        ev_snap;

  cpu_run_ctrl_if #(.CNT_W(CW)) bus ();

  cpu_run_ctrl #(.RST_CYCLES(4), .CNT_W(CW)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.instr = (bus.pc == eb_pc) ? EBREAK_INSN : 32'h0000_0013;

  // Minimal CPU: PC advances by one word on each committed instruction
  always @(posedge clk) begin
    if (rst_s)     bus.pc <= 32'h0;
    else if (ce_s) bus.pc <= bus.pc + 32'd4;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  always @(negedge clk) begin
    ce_s  = bus.cpu_ce;
    rst_s = bus.cpu_reset;
    if (bus.cpu_ce === 1'b1) begin
      if (q_commit.size() == 0) unexpected("commit", bus.pc);
      else chk("commit_pc", bus.pc, q_commit.pop_front());
    end
    if (bus.halted === 1'b1 && !prev_h) begin
      if (q_halt.size() == 0) unexpected("halt", bus.halt_cause);
      else begin
        halt_t h;
        h = q_halt.pop_front();
        chk("halt_cause", bus.halt_cause, h.cause);
        chk("halt_instret", bus.instret, h.cnt);
      end
    end
    if (!rst_n) rlen = 0;
    else if (bus.cpu_reset === 1'b1) rlen++;
    else if (prev_cr) begin
      if (q_rstlen.size() == 0) unexpected("reset_len", rlen);
      else chk("reset_len", rlen, q_rstlen.pop_front());
    end
    prev_h  = bus.halted;
    prev_cr = bus.cpu_reset;
  end

  initial forever begin
    @(ev_snap);
    if (q_snap.size() == 0) unexpected("reset_snap", bus.instret);
    else chk("reset_snap", {bus.cpu_reset, bus.cpu_ce, bus.halted, bus.instret}, q_snap.pop_front());
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_halt(input logic [1:0] c, input int n);
    q_halt.push_back('{cause: c, cnt: CW'(n)});
  endtask

  task automatic exp_commits(input int first_pc, input int n);
    for (int i = 0; i < n; i++) q_commit.push_back(32'(first_pc + 4 * i));
  endtask

  task automatic press_step();
    bus.step_btn = 1'b1;
    tick(3);
    bus.step_btn = 1'b0;
    tick(6);
  endtask

  task automatic press_run();
    bus.run_btn = 1'b1;
    tick(3);
    bus.run_btn = 1'b0;
    tick(12);
  endtask

  initial begin
    bus.run_btn  = 1'b0;
    bus.step_btn = 1'b0;
    bus.halt_btn = 1'b0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 32'h0;

    // Power-up: four reset cycles, then HALT with manual cause
    q_rstlen.push_back(4);
    exp_halt(CAUSE_MAN, 0);
    tick(3);
    rst_n = 1'b1;
    tick(10);

    // Three single steps at pc 0, 4, 8
    for (int i = 0; i < 3; i++) begin
      exp_commits(4 * i, 1);
      exp_halt(CAUSE_STEP, i + 1);
      press_step();
    end

    // Breakpoint at 0x10 stops before committing it
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h10;
    exp_commits(32'hC, 1);
    exp_halt(CAUSE_BP, 4);
    press_run();

    // Resume commits 0x10 once, runs on to EBREAK at 0x20
    exp_commits(32'h10, 4);
    exp_halt(CAUSE_EBRK, 8);
    press_run();

    // Step onto EBREAK: no commit, cause ebreak
    exp_halt(CAUSE_EBRK, 8);
    press_step();

    // Run and step together: run wins, stops on breakpoint 0x30
    eb_pc       = 32'hFFFF_FFFC;
    bus.bp_addr = 32'h30;
    exp_commits(32'h20, 4);
    exp_halt(CAUSE_BP, 12);
    bus.run_btn  = 1'b1;
    bus.step_btn = 1'b1;
    tick(3);
    bus.run_btn  = 1'b0;
    bus.step_btn = 1'b0;
    tick(12);

    // Halt pulse during STEP is ignored; step ignores the breakpoint at 0x30
    exp_commits(32'h30, 1);
    exp_halt(CAUSE_STEP, 13);
    bus.step_btn = 1'b1;
    tick(1);
    bus.halt_btn = 1'b1;
    tick(3);
    bus.step_btn = 1'b0;
    bus.halt_btn = 1'b0;
    tick(8);

    // Manual halt four cycles after run press: three commits
    bus.bp_en = 1'b0;
    exp_commits(32'h34, 3);
    exp_halt(CAUSE_MAN, 16);
    bus.run_btn = 1'b1;
    tick(4);
    bus.halt_btn = 1'b1;
    tick(3);
    bus.run_btn  = 1'b0;
    bus.halt_btn = 1'b0;
    tick(8);

    // Controller reset mid-RUN takes effect immediately
    exp_commits(32'h40, 3);
    bus.run_btn = 1'b1;
    tick(3);
    bus.run_btn = 1'b0;
    tick(4);
    #1;
    rst_n = 1'b0;
    #1;
    q_snap.push_back('{cpu_reset: 1'b1, cpu_ce: 1'b0, halted: 1'b0, instret: '0});
    -> ev_snap;
    q_rstlen.push_back(4);
    exp_halt(CAUSE_MAN, 0);
    tick(3);
    rst_n = 1'b1;
    tick(10);

    // Long run: 299 commits saturate the 8-bit counter at 255
    exp_commits(0, 299);
    exp_halt(CAUSE_MAN, 255);
    bus.run_btn = 1'b1;
    tick(300);
    bus.halt_btn = 1'b1;
    tick(3);
    bus.run_btn  = 1'b0;
    bus.halt_btn = 1'b0;
    tick(10);

    chk("commit_q_empty", q_commit.size(), 0);
    chk("halt_q_empty", q_halt.size(), 0);
    chk("rstlen_q_empty", q_rstlen.size(), 0);
    chk("snap_q_empty", q_snap.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
